// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: manual modes, burst FSM states, directions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package univ_shift_reg_pkg;

  // Manual operation encoding on the mode input.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Burst direction encoding on the dir input.
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  // Burst engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } burst_state_e;

  // Saturate a requested burst length to the register width, so a burst never shifts more
  // than one full flush.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return (len > width) ? width : len;
  endfunction

endpackage

// File: rtl/univ_shift_ctrl.sv
// Burst controller: accepts start, clamps len to WIDTH, strobes one shift per cycle, then pulses done.
// Latency: first shift strobe one cycle after acceptance; done one cycle after the last shift.
// Backpressure: none; start is only honoured in IDLE and is ignored while busy.
// Optional rotate latch present when UNIV_SHIFT_REG_ROTATE_EN is defined.
module univ_shift_ctrl
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic          rot,
  output logic          shift_rot,
`endif
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [LW-1:0] len,
  output logic          shift_stb,
  output logic          shift_dir,
  output logic          busy,
  output logic          done
);

  localparam logic [LW-1:0] WIDTH_L = LW'(clamp_len(WIDTH, WIDTH));
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  burst_state_e  state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic          dir_q, dir_nxt;
  logic [LW-1:0] len_clamped;

  // Saturate the requested length; len is wide enough to exceed WIDTH.
  always_comb begin
    len_clamped = (len > WIDTH_L) ? WIDTH_L : len;
  end

  // State, remaining-shift counter and latched direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= DIR_R;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
    end
  end

  // Next-state and outputs; a zero-length burst skips RUN and goes straight to DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    shift_stb = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          dir_nxt   = dir;
          cnt_nxt   = len_clamped;
          state_nxt = (len_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        shift_stb = 1'b1;
        cnt_nxt   = cnt - ONE_L;
        if (cnt == ONE_L) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign shift_dir = dir_q;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  logic rot_q;

  // Rotate selection is captured with the burst so it cannot change mid-burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start) begin
      rot_q <= rot;
    end
  end

  assign shift_rot = rot_q;
`endif

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold/shift-right/shift-left/load plus a counted burst shifter.
// Latency: manual ops update q on the sampling edge (1 cycle); burst of L shifts ends with done at L+1.
// Backpressure: none; manual controls and new bursts are ignored while busy.
// Build option UNIV_SHIFT_REG_ROTATE_EN adds the rot input (end-around rotation instead of serial in).
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sr_in,
  input  logic                       sl_in,
  input  logic                       start,
  input  logic                       dir,
  input  logic [$clog2(WIDTH+1)-1:0] len,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic                       rot,
`endif
  output logic [WIDTH-1:0]           q,
  output logic                       so_r,
  output logic                       so_l,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(WIDTH + 1);

  logic             shift_stb;
  logic             shift_dir;
  logic             man_en;
  logic             rin_man, lin_man;
  logic             rin_bst, lin_bst;
  logic [WIDTH-1:0] q_nxt;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  logic shift_rot;
`endif

  univ_shift_ctrl #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_ctrl (
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot       (rot),
    .shift_rot (shift_rot),
`endif
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .len       (len),
    .shift_stb (shift_stb),
    .shift_dir (shift_dir),
    .busy      (busy),
    .done      (done)
  );

  // Manual ops run only in IDLE and lose to a simultaneous start.
  assign man_en = en && !busy && !start;

  // Bits entering the vacated end: serial inputs, or the opposite end when rotating.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign rin_man = rot       ? q[0]       : sr_in;
  assign lin_man = rot       ? q[WIDTH-1] : sl_in;
  assign rin_bst = shift_rot ? q[0]       : sr_in;
  assign lin_bst = shift_rot ? q[WIDTH-1] : sl_in;
`else
  assign rin_man = sr_in;
  assign lin_man = sl_in;
  assign rin_bst = sr_in;
  assign lin_bst = sl_in;
`endif

  // Next register value: burst strobe first, then manual mode, otherwise hold.
  always_comb begin
    q_nxt = q;
    if (shift_stb) begin
      if (shift_dir == DIR_L) begin
        q_nxt = {q[WIDTH-2:0], lin_bst};
      end else begin
        q_nxt = {rin_bst, q[WIDTH-1:1]};
      end
    end else if (man_en) begin
      case (mode)
        MODE_SHR:  q_nxt = {rin_man, q[WIDTH-1:1]};
        MODE_SHL:  q_nxt = {q[WIDTH-2:0], lin_man};
        MODE_LOAD: q_nxt = d;
        default:   q_nxt = q;
      endcase
    end
  end

  // Data-path register; reset returns to RESET_VAL immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next.
// Backpressure: n/a.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sr_in, sl_in;
  logic         start, dir;
  logic [3:0]   len;
  logic         rot;
  logic [W-1:0] q;
  logic         so_r, so_l, busy, done;

  int tests = 0;
  int fails = 0;

  univ_shift_reg #(
    .WIDTH     (W),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sr_in (sr_in),
    .sl_in (sl_in),
    .start (start),
    .dir   (dir),
    .len   (len),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot   (rot),
`endif
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0;
    sr_in = 1'b0; sl_in = 1'b0; start = 1'b0; dir = DIR_R; len = '0; rot = 1'b0;

    // Reset state, in and out of reset.
    tick(); tick();
    chk_st("rst_in", 8'hA5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_st("rst_out", 8'hA5, 1'b0, 1'b0);
    chk("rst_so_l", 32'(so_l), 32'd1);

    // Load then shift right twice.
    en = 1'b1; mode = MODE_LOAD; d = 8'h3C;
    tick();
    chk("load_3c", 32'(q), 32'h3C);
    mode = MODE_SHR; sr_in = 1'b0;
    tick();
    chk("shr1", 32'(q), 32'h1E);
    chk("shr1_so_r", 32'(so_r), 32'd0);
    sr_in = 1'b1;
    tick();
    chk("shr2", 32'(q), 32'h8F);
    chk("shr2_so_r", 32'(so_r), 32'd1);
    chk("shr2_so_l", 32'(so_l), 32'd1);
    mode = MODE_SHL; sl_in = 1'b1;
    tick();
    chk("shl1", 32'(q), 32'h1F);
    mode = MODE_HOLD;
    tick();
    chk("hold", 32'(q), 32'h1F);
    en = 1'b0; mode = MODE_LOAD; d = 8'h00;
    tick();
    chk("en_off", 32'(q), 32'h1F);

    // Left burst of 3 from 8'h81; manual load during the burst must be ignored.
    en = 1'b1; mode = MODE_LOAD; d = 8'h81;
    tick();
    start = 1'b1; dir = DIR_L; len = 4'd3; sl_in = 1'b0; d = 8'hFF;
    tick();
    chk_st("bl_e0", 8'h81, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("bl_e1", 8'h02, 1'b1, 1'b0);
    start = 1'b1; dir = DIR_R; len = 4'd1;
    tick();
    chk_st("bl_e2", 8'h04, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("bl_e3", 8'h08, 1'b1, 1'b1);
    tick();
    chk_st("bl_e4", 8'h08, 1'b0, 1'b0);
    en = 1'b0;

    // Clamped flush: len 15 shifts exactly 8 times.
    en = 1'b1; mode = MODE_LOAD; d = 8'hFF;
    tick();
    en = 1'b0; start = 1'b1; dir = DIR_R; len = 4'd15; sr_in = 1'b0;
    tick();
    chk_st("fl_e0", 8'hFF, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk_st("fl_e7", 8'h01, 1'b1, 1'b0);
    tick();
    chk_st("fl_e8", 8'h00, 1'b1, 1'b1);
    tick();
    chk_st("fl_e9", 8'h00, 1'b0, 1'b0);

    // Zero-length burst: immediate done, no shift.
    en = 1'b1; mode = MODE_LOAD; d = 8'h5A;
    tick();
    en = 1'b0; start = 1'b1; len = 4'd0; sr_in = 1'b1;
    tick();
    chk_st("z_e0", 8'h5A, 1'b1, 1'b1);
    start = 1'b0;
    tick();
    chk_st("z_e1", 8'h5A, 1'b0, 1'b0);

    // Reset during a 5-shift burst aborts without done.
    start = 1'b1; dir = DIR_R; len = 4'd5; sr_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_st("ab_e1", 8'hAD, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_st("ab_rst", 8'hA5, 1'b0, 1'b0);
    tick(); tick();
    chk_st("ab_hold", 8'hA5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_st("ab_rel", 8'hA5, 1'b0, 1'b0);
    start = 1'b1; dir = DIR_L; len = 4'd1; sl_in = 1'b1;
    tick();
    chk_st("nb_e0", 8'hA5, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("nb_e1", 8'h4B, 1'b1, 1'b1);
    tick();
    chk_st("nb_e2", 8'h4B, 1'b0, 1'b0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Rotation replaces the serial inputs with the opposite end bit.
    en = 1'b1; mode = MODE_LOAD; d = 8'h01;
    tick();
    mode = MODE_SHR; rot = 1'b1; sr_in = 1'b0;
    tick();
    chk("rot_r", 32'(q), 32'h80);
    mode = MODE_SHL; sl_in = 1'b0;
    tick();
    chk("rot_l", 32'(q), 32'h01);
    en = 1'b0; start = 1'b1; dir = DIR_R; len = 4'd2;
    tick();
    start = 1'b0; rot = 1'b0;
    tick(); tick();
    chk("rot_burst", 32'(q), 32'h40);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
